// File: rtl/placer_host_sequencer.sv
// Host-side sequencer for placer_interface: loads packets into BRAM port B, runs the
// done/ack mailbox per packet and for the run phase, then streams the results back out.
module placer_host_sequencer #(
  parameter int N           = 4,
  parameter int ADDR_W      = 13,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic              m_last,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_out,
  input  logic [31:0]       data_in,
  output logic [3:0]        we,
  output logic              ram_en,
  output logic              done,
  input  logic              ack,
  output logic              busy,
  output logic              error
);

  localparam int PACKET_WORDS = N + 8;
  localparam int NUM_PACKETS  = N + 2;
  localparam int RESULT_WORDS = N;
  localparam int KW  = $clog2(PACKET_WORDS + 1);
  localparam int PW  = $clog2(NUM_PACKETS + 1);
  localparam int IW  = $clog2(RESULT_WORDS + 1);
  localparam int WDW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    WR_LAST = 4'd2,
    HS_HI   = 4'd3,
    HS_LO   = 4'd4,
    RUN_HI  = 4'd5,
    RUN_LO  = 4'd6,
    RD_ADDR = 4'd7,
    RD_WAIT = 4'd8,
    EMIT    = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [PW-1:0]     pkt_q, pkt_d;
  logic [IW-1:0]     i_q, i_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [31:0]       m_data_q, m_data_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [31:0]       data_out_q, data_out_d;
  logic [3:0]        we_q, we_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic              in_ack;
  logic              wd_expired;

  // Byte address of a word index, truncated to the port width.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] idx);
    logic [31:0] byte_addr;
    byte_addr = idx << 2;
    return byte_addr[ADDR_W-1:0];
  endfunction

  assign in_ack     = state_q inside {HS_HI, HS_LO, RUN_HI, RUN_LO};
  assign wd_expired = (ACK_TIMEOUT != 0) && (wd_q == WDW'(ACK_TIMEOUT - 1));

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pkt_d      = pkt_q;
    i_d        = i_q;
    wd_d       = wd_q;
    s_ready_d  = s_ready_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_data_d   = m_data_q;
    address_d  = address_q;
    data_out_d = data_out_q;
    we_d       = 4'h0;
    done_d     = done_q;
    busy_d     = busy_q;
    error_d    = error_q;
    if (in_ack && wd_expired) begin
      error_d = 1'b1;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !ack) begin
            k_d       = '0;
            pkt_d     = '0;
            i_d       = '0;
            error_d   = 1'b0;
            busy_d    = 1'b1;
            s_ready_d = 1'b1;
            state_d   = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          if (s_valid && s_ready_q) begin
            address_d  = word_addr(32'(k_q));
            data_out_d = s_data;
            we_d       = 4'hF;
            if (k_q == KW'(PACKET_WORDS - 1)) begin
              k_d       = '0;
              s_ready_d = 1'b0;
              state_d   = WR_LAST;
            end else begin
              k_d = k_q + KW'(1);
            end
          end else begin
            state_d = LOAD;
          end
        end
        // The final write is on the bus this cycle; done follows it.
        WR_LAST: begin
          done_d  = 1'b1;
          state_d = HS_HI;
        end
        HS_HI: begin
          if (ack) begin
            done_d  = 1'b0;
            pkt_d   = pkt_q + PW'(1);
            state_d = HS_LO;
          end else begin
            state_d = HS_HI;
          end
        end
        HS_LO: begin
          if (!ack) begin
            if (pkt_q < PW'(NUM_PACKETS)) begin
              s_ready_d = 1'b1;
              state_d   = LOAD;
            end else begin
              done_d  = 1'b1;
              state_d = RUN_HI;
            end
          end else begin
            state_d = HS_LO;
          end
        end
        RUN_HI: begin
          if (ack) begin
            done_d  = 1'b0;
            state_d = RUN_LO;
          end else begin
            state_d = RUN_HI;
          end
        end
        // Address is presented on entry to RD_ADDR so data_in is valid in RD_WAIT.
        RUN_LO: begin
          if (!ack) begin
            i_d       = '0;
            address_d = word_addr(32'd0);
            state_d   = RD_ADDR;
          end else begin
            state_d = RUN_LO;
          end
        end
        RD_ADDR: state_d = RD_WAIT;
        RD_WAIT: begin
          m_data_d  = data_in;
          m_valid_d = 1'b1;
          m_last_d  = (i_q == IW'(RESULT_WORDS - 1));
          state_d   = EMIT;
        end
        EMIT: begin
          if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            if (m_last_q) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              i_d       = i_q + IW'(1);
              address_d = word_addr(32'(i_q) + 32'd1);
              state_d   = RD_ADDR;
            end
          end else begin
            state_d = EMIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (in_ack) begin
      wd_d = wd_q + WDW'(1);
    end else begin
      wd_d = '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      pkt_q      <= '0;
      i_q        <= '0;
      wd_q       <= '0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= 32'h0;
      address_q  <= '0;
      data_out_q <= 32'h0;
      we_q       <= 4'h0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pkt_q      <= pkt_d;
      i_q        <= i_d;
      wd_q       <= wd_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
      we_q       <= we_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign m_data   = m_data_q;
  assign address  = address_q;
  assign data_out = data_out_q;
  assign we       = we_q;
  assign ram_en   = 1'b1;
  assign done     = done_q;
  assign busy     = busy_q;
  assign error    = error_q;

endmodule

// File: tb/tb_placer_host_sequencer.sv
// Directed/randomized bench for placer_host_sequencer with a BRAM model and a
// placer-side mailbox driven from the stimulus sequence.
module tb_placer_host_sequencer;

  localparam int N      = 4;
  localparam int ADDR_W = 13;
  localparam int PWORDS = N + 8;
  localparam int NPKT   = N + 2;
  localparam int NRES   = N;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_data;
  logic              m_last;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_out;
  logic [31:0]       data_in;
  logic [3:0]        we;
  logic              ram_en;
  logic              done;
  logic              ack;
  logic              busy;
  logic              error;

  logic [31:0] mem [16];
  logic        pa_we;
  logic [3:0]  pa_addr;
  logic [31:0] pa_data;
  logic [31:0] pkt [PWORDS];
  logic [31:0] res [NRES];
  int          nvec = 0;
  int          nerr = 0;
  int          we_pulses = 0;
  int          done_rises = 0;
  logic        done_p = 1'b0;

  placer_host_sequencer #(.N(N), .ADDR_W(ADDR_W), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .address(address), .data_out(data_out), .data_in(data_in), .we(we), .ram_en(ram_en),
    .done(done), .ack(ack), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // BRAM: port A for the placer model, port B for the DUT, 1-cycle read.
  always @(posedge clk) begin
    if (pa_we) mem[pa_addr] <= pa_data;
    if (we == 4'hF) mem[address[5:2]] <= data_out;
    data_in <= mem[address[5:2]];
  end

  // Count write pulses and done rising edges.
  always @(posedge clk) begin
    done_p <= done;
    if (we == 4'hF) we_pulses <= we_pulses + 1;
    if (done && !done_p) done_rises <= done_rises + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench did not terminate");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({p, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({p, "_m_last"}, 32'(m_last), 32'd0);
    chk({p, "_done"}, 32'(done), 32'd0);
    chk({p, "_busy"}, 32'(busy), 32'd0);
    chk({p, "_error"}, 32'(error), 32'd0);
    chk({p, "_we"}, 32'(we), 32'd0);
    chk({p, "_address"}, 32'(address), 32'd0);
    chk({p, "_data_out"}, data_out, 32'd0);
    chk({p, "_m_data"}, m_data, 32'd0);
    chk({p, "_ram_en"}, 32'(ram_en), 32'd1);
  endtask

  task automatic start_job();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_error_clr", 32'(error), 32'd0);
    chk("start_s_ready", 32'(s_ready), 32'd1);
  endtask

  // Streams packet p; returns at the cycle where done must have just risen.
  task automatic feed_packet(input int p, input bit rnd);
    int k = 0;
    int guard = 0;
    int we0 = we_pulses;
    for (int j = 0; j < PWORDS; j++) pkt[j] = rnd ? $urandom : 32'h1000 + 32'(12 * p + j);
    while (k < PWORDS && guard < 400) begin
      @(negedge clk);
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = pkt[k];
      if (s_valid && s_ready) k++;
      guard++;
    end
    chk("load_words", 32'(k), 32'(PWORDS));
    @(negedge clk);
    s_valid = 1'b0;
    chk("t1_we", 32'(we), 32'hF);
    chk("t1_s_ready", 32'(s_ready), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_we", 32'(we), 32'd0);
    chk("we_count", 32'(we_pulses - we0), 32'(PWORDS));
    for (int j = 0; j < PWORDS; j++) chk("bram_word", mem[j], pkt[j]);
  endtask

  task automatic handshake(input bit rnd, input bit poke_start);
    repeat (rnd ? $urandom_range(0, 3) : 0) begin
      @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
    end
    if (poke_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_done", 32'(done), 32'd1);
      chk("busy_start_busy", 32'(busy), 32'd1);
      chk("busy_start_s_ready", 32'(s_ready), 32'd0);
    end
    ack = 1'b1;
    @(negedge clk);
    chk("ack_done_drop", 32'(done), 32'd0);
    repeat (rnd ? $urandom_range(0, 2) : 0) @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic drain(input bit stall);
    for (int r = 0; r < NRES; r++) begin
      int g = 0;
      m_ready = 1'b0;
      do begin
        @(negedge clk);
        g++;
      end while (!m_valid && g < 20);
      chk("m_valid", 32'(m_valid), 32'd1);
      chk("m_data", m_data, res[r]);
      chk("m_last", 32'(m_last), 32'(r == NRES - 1));
      if (stall) begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_m_data", m_data, res[r]);
          chk("stall_m_valid", 32'(m_valid), 32'd1);
        end
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk("post_beat_m_valid", 32'(m_valid), 32'd0);
    end
    chk("end_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("no_extra_beat", 32'(m_valid), 32'd0);
  endtask

  // mode 0: complete job, 1: placer never acks packet 2, 2: reset during RUN_HI
  task automatic do_job(input bit rnd, input int mode, input bit poke);
    int d0 = done_rises;
    int g = 0;
    for (int r = 0; r < NRES; r++) res[r] = rnd ? $urandom : 32'hA0 + 32'(r);
    start_job();
    for (int p = 0; p < NPKT; p++) begin
      feed_packet(p, rnd);
      if (mode == 1 && p == 2) begin
        repeat (15) @(negedge clk);
        chk("wd_pre_error", 32'(error), 32'd0);
        chk("wd_pre_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("wd_error", 32'(error), 32'd1);
        chk("wd_done", 32'(done), 32'd0);
        chk("wd_busy", 32'(busy), 32'd0);
        chk("wd_s_ready", 32'(s_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("wd_sticky", 32'(error), 32'd1);
        return;
      end
      handshake(rnd, poke && p == 2);
    end
    do begin
      @(negedge clk);
      g++;
    end while (!done && g < 20);
    chk("run_done", 32'(done), 32'd1);
    if (mode == 2) begin
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      reset_checks("midrst");
      return;
    end
    for (int r = 0; r < NRES; r++) begin
      @(negedge clk);
      pa_we = 1'b1;
      pa_addr = 4'(r);
      pa_data = res[r];
      chk("run_no_we", 32'(we), 32'd0);
    end
    @(negedge clk);
    pa_we = 1'b0;
    chk("run_done_hold", 32'(done), 32'd1);
    ack = 1'b1;
    @(negedge clk);
    chk("run_ack_done", 32'(done), 32'd0);
    ack = 1'b0;
    drain(rnd);
    chk("done_pulses", 32'(done_rises - d0), 32'(NPKT + 1));
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = 32'h0;
    m_ready = 1'b0;
    ack = 1'b0;
    pa_we = 1'b0;
    pa_addr = 4'h0;
    pa_data = 32'h0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst = 1'b1;

    do_job(1'b0, 0, 1'b1);

    ack = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ack_start_busy", 32'(busy), 32'd0);
    chk("ack_start_s_ready", 32'(s_ready), 32'd0);
    ack = 1'b0;
    @(negedge clk);
    chk("ack_start_busy2", 32'(busy), 32'd0);

    do_job(1'b1, 0, 1'b0);
    do_job(1'b1, 1, 1'b0);
    do_job(1'b0, 2, 1'b0);
    do_job(1'b1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
